// File: rtl/div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_unit: iterative RV32M DIV/DIVU/REM/REMU restoring divider.       |
// | Signed ops are built only when DIV_SIGNED_EN is defined.   Rev 1.0   |
// +----------------------------------------------------------------------+
module div_unit #(
  parameter int word_width = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [word_width-1:0] dividend,
  input  logic [word_width-1:0] divisor,
  output logic                  busy,
  output logic                  wren,
  output logic [word_width-1:0] data_out
);

  localparam int c_cnt_w = (word_width > 1) ? $clog2(word_width) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(word_width - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [c_cnt_w-1:0]    cnt_q, cnt_d;
  logic                  op_rem_q, op_rem_d;
  logic                  div_zero_q, div_zero_d;
  logic [word_width-1:0] dvd_orig_q, dvd_orig_d;
  logic [word_width-1:0] dvs_mag_q, dvs_mag_d;
  logic [word_width-1:0] quo_q, quo_d;
  logic [word_width-1:0] rem_q, rem_d;
  logic                  busy_q, busy_d;
  logic                  wren_q, wren_d;
  logic [word_width-1:0] data_out_q, data_out_d;

  logic [word_width-1:0] w_dvd_mag;
  logic [word_width-1:0] w_dvs_mag;
  logic [word_width:0]   w_shift;
  logic [word_width:0]   w_trial;
  logic [word_width-1:0] w_quo_res;
  logic [word_width-1:0] w_rem_res;

`ifdef DIV_SIGNED_EN
  localparam logic [word_width-1:0] c_min = {1'b1, {(word_width-1){1'b0}}};

  logic quo_neg_q, quo_neg_d;
  logic rem_neg_q, rem_neg_d;
  logic ovf_q, ovf_d;
  logic w_is_signed;

  assign w_is_signed = ~op[0];
  assign w_dvd_mag   = (w_is_signed && dividend[word_width-1]) ? -dividend : dividend;
  assign w_dvs_mag   = (w_is_signed && divisor[word_width-1])  ? -divisor  : divisor;
`else
  logic unused_op0;

  assign unused_op0 = op[0];
  assign w_dvd_mag  = dividend;
  assign w_dvs_mag  = divisor;
`endif

  // One restoring step: the extra top bit of w_trial is the borrow.
  assign w_shift = {rem_q, quo_q[word_width-1]};
  assign w_trial = w_shift - {1'b0, dvs_mag_q};

  always_comb begin
    w_quo_res = quo_q;
    w_rem_res = rem_q;
`ifdef DIV_SIGNED_EN
    if (quo_neg_q) w_quo_res = -quo_q;
    if (rem_neg_q) w_rem_res = -rem_q;
    if (ovf_q) begin
      w_quo_res = c_min;
      w_rem_res = '0;
    end
`endif
    if (div_zero_q) begin
      w_quo_res = '1;
      w_rem_res = dvd_orig_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_rem_d   = op_rem_q;
    div_zero_d = div_zero_q;
    dvd_orig_d = dvd_orig_q;
    dvs_mag_d  = dvs_mag_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    busy_d     = busy_q;
    wren_d     = 1'b0;
    data_out_d = data_out_q;
`ifdef DIV_SIGNED_EN
    quo_neg_d  = quo_neg_q;
    rem_neg_d  = rem_neg_q;
    ovf_d      = ovf_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_CALC;
          cnt_d      = '0;
          op_rem_d   = op[1];
          div_zero_d = (divisor == '0);
          dvd_orig_d = dividend;
          dvs_mag_d  = w_dvs_mag;
          quo_d      = w_dvd_mag;
          rem_d      = '0;
          busy_d     = 1'b1;
`ifdef DIV_SIGNED_EN
          quo_neg_d  = w_is_signed & (dividend[word_width-1] ^ divisor[word_width-1]);
          rem_neg_d  = w_is_signed & dividend[word_width-1];
          ovf_d      = w_is_signed && (dividend == c_min) && (divisor == '1);
`endif
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end

      S_CALC: begin
        if (!w_trial[word_width]) begin
          rem_d = w_trial[word_width-1:0];
          quo_d = {quo_q[word_width-2:0], 1'b1};
        end else begin
          rem_d = w_shift[word_width-1:0];
          quo_d = {quo_q[word_width-2:0], 1'b0};
        end
        cnt_d = cnt_q + c_cnt_w'(1);
        if (cnt_q == c_last) state_d = S_FIXUP;
      end

      S_FIXUP: begin
        data_out_d = op_rem_q ? w_rem_res : w_quo_res;
        wren_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = S_DONE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_rem_q   <= 1'b0;
      div_zero_q <= 1'b0;
      dvd_orig_q <= '0;
      dvs_mag_q  <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      busy_q     <= 1'b0;
      wren_q     <= 1'b0;
      data_out_q <= '0;
`ifdef DIV_SIGNED_EN
      quo_neg_q  <= 1'b0;
      rem_neg_q  <= 1'b0;
      ovf_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_rem_q   <= op_rem_d;
      div_zero_q <= div_zero_d;
      dvd_orig_q <= dvd_orig_d;
      dvs_mag_q  <= dvs_mag_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      busy_q     <= busy_d;
      wren_q     <= wren_d;
      data_out_q <= data_out_d;
`ifdef DIV_SIGNED_EN
      quo_neg_q  <= quo_neg_d;
      rem_neg_q  <= rem_neg_d;
      ovf_q      <= ovf_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign wren     = wren_q;
  assign data_out = data_out_q;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_div_unit: randomized bench for div_unit against an arithmetic     |
// | reference model.                                         Rev 1.0     |
// +----------------------------------------------------------------------+
module tb_div_unit;

  localparam int W = 32;
`ifdef DIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
  localparam logic [31:0] L_DIV_M7_2  = 32'hFFFFFFFD;
  localparam logic [31:0] L_REM_M7_2  = 32'hFFFFFFFF;
  localparam logic [31:0] L_DIV_7_M2  = 32'hFFFFFFFD;
  localparam logic [31:0] L_DIV_OVF   = 32'h80000000;
  localparam logic [31:0] L_REM_OVF   = 32'h00000000;
`else
  localparam bit SIGNED_EN = 1'b0;
  localparam logic [31:0] L_DIV_M7_2  = 32'h7FFFFFFC;
  localparam logic [31:0] L_REM_M7_2  = 32'h00000001;
  localparam logic [31:0] L_DIV_7_M2  = 32'h00000000;
  localparam logic [31:0] L_DIV_OVF   = 32'h00000000;
  localparam logic [31:0] L_REM_OVF   = 32'h80000000;
`endif

  logic          clk;
  logic          reset;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  dividend;
  logic [W-1:0]  divisor;
  logic          busy;
  logic          wren;
  logic [W-1:0]  data_out;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Expected outputs, advanced by the reference model on each rising edge.
  logic          exp_busy = 1'b0;
  logic          exp_wren = 1'b0;
  logic [W-1:0]  exp_data = '0;
  logic [W-1:0]  pending  = '0;
  int            remaining = 0;

  div_unit #(.word_width(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .wren     (wren),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return o[1] ? a : 32'hFFFFFFFF;
    if (SIGNED_EN && !o[0]) begin
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) return o[1] ? 32'd0 : 32'h80000000;
      return o[1] ? (sa % sb) : (sa / sb);
    end
    return o[1] ? (a % b) : (a / b);
  endfunction

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: a start seen while idle yields its result W+1 edges later.
  always @(posedge clk) begin
    if (reset) begin
      exp_busy  = 1'b0;
      exp_wren  = 1'b0;
      exp_data  = '0;
      remaining = 0;
    end else begin
      exp_wren = 1'b0;
      if (remaining > 0) begin
        remaining--;
        if (remaining == 0) begin
          exp_busy = 1'b0;
          exp_wren = 1'b1;
          exp_data = pending;
        end
      end else if (start) begin
        pending   = model(op, dividend, divisor);
        remaining = W + 1;
        exp_busy  = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check_eq("busy", {31'd0, busy}, {31'd0, exp_busy});
      check_eq("wren", {31'd0, wren}, {31'd0, exp_wren});
      check_eq("data_out", data_out, exp_data);
      check_eq("busy_and_wren", {31'd0, busy & wren}, 32'd0);
    end
  end

  // Starts an op now (caller sits just after a falling edge); optionally
  // re-pulses start with other operands at falling edge number inject_at.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int inject_at, output int n);
    op = o; dividend = a; divisor = b; start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      start    = (n == inject_at);
      op       = 2'($urandom);
      dividend = $urandom;
      divisor  = $urandom;
    end while (!wren && n < 100);
  endtask

  // wren rises at edge E0+W+1, i.e. on the W+2'th falling edge counted by run_op.
  task automatic directed(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] lit, input string name);
    int n;
    @(negedge clk);
    check_eq({"model_", name}, model(o, a, b), lit);
    run_op(o, a, b, 0, n);
    check_eq({"latency_", name}, 32'(n), 32'(W + 2));
    check_eq({"result_", name}, data_out, lit);
  endtask

  initial begin
    int n;
    bit saw_wren;
    reset = 1'b1; start = 1'b0; op = 2'b00; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_busy", {31'd0, busy}, 32'd0);
    check_eq("reset_wren", {31'd0, wren}, 32'd0);
    check_eq("reset_data", data_out, 32'd0);
    reset  = 1'b0;
    cmp_en = 1'b1;

    directed(2'b01, 32'd100, 32'd7, 32'd14, "divu_100_7");
    directed(2'b11, 32'd100, 32'd7, 32'd2, "remu_100_7");
    directed(2'b00, -32'd7, 32'd2, L_DIV_M7_2, "div_m7_2");
    directed(2'b10, -32'd7, 32'd2, L_REM_M7_2, "rem_m7_2");
    directed(2'b00, 32'd7, -32'd2, L_DIV_7_M2, "div_7_m2");
    directed(2'b00, 32'h12345678, 32'd0, 32'hFFFFFFFF, "div_by_zero");
    directed(2'b10, -32'd5, 32'd0, 32'hFFFFFFFB, "rem_m5_by_zero");
    directed(2'b11, 32'd9, 32'd0, 32'd9, "remu_9_by_zero");
    directed(2'b00, 32'h80000000, 32'hFFFFFFFF, L_DIV_OVF, "div_ovf");
    directed(2'b10, 32'h80000000, 32'hFFFFFFFF, L_REM_OVF, "rem_ovf");

    // Start while busy is ignored; start in the DONE cycle is taken.
    @(negedge clk);
    run_op(2'b01, 32'd1000, 32'd10, 6, n);
    check_eq("ignore_busy_result", data_out, 32'd100);
    check_eq("ignore_busy_latency", 32'(n), 32'(W + 2));
    run_op(2'b01, 32'd50, 32'd5, 0, n);
    check_eq("b2b_spacing", 32'(n), 32'(W + 2));
    check_eq("b2b_result", data_out, 32'd10);

    // Reset in the middle of CALC aborts with no result.
    @(negedge clk);
    op = 2'b01; dividend = 32'd1000; divisor = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    check_eq("abort_wren", {31'd0, wren}, 32'd0);
    check_eq("abort_data", data_out, 32'd0);
    saw_wren = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (wren) saw_wren = 1'b1;
    end
    check_eq("abort_no_wren", {31'd0, saw_wren}, 32'd0);
    directed(2'b01, 32'd1000, 32'd7, 32'd142, "after_abort");

    // Random traffic: start pulses land in every state; rare resets.
    repeat (6000) begin
      @(negedge clk);
      start    = ($urandom_range(0, 3) == 0);
      op       = 2'($urandom);
      dividend = rand_opnd();
      divisor  = rand_opnd();
      reset    = ($urandom_range(0, 1499) == 0);
    end
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    repeat (40) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
